oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite DMA controller behind CPU register $4014.
- A CPU write of page P halts the CPU and copies 256 bytes from CPU addresses P*256..P*256+255 into the PPU OAM data port $2004.
- It sits between the CPU core and the shared CPU memory bus, which also carries the PPU register interface.
- It owns that bus while the transfer runs.

Parameters:
- OAMDATA_ADDR, 16'h2004, destination address of every DMA write.
- NBYTES, 256, bytes per transfer; must be a power of two, maximum 256.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; all state and outputs return to reset values on the next clk edge.
- tick  input  1  CPU-cycle enable; all state advances happen only on clk edges where tick=1.
- wr4014  input  1  CPU write strobe for $4014, qualified by tick.
- cpuwdata  input  8  CPU write data; the source page.
- halt  output  1  stalls the CPU core while high.
- dmaaddr  output  16  bus address.
- dmawdata  output  8  bus write data.
- dmawr  output  1  1 = write, 0 = read.
- dmareq  output  1  bus request, level.
- dmaack  input  1  bus acknowledge, one clk pulse; read data is valid in the same cycle.
- dmardata  input  8  bus read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: halt=0, busy=0, dmareq=0, dmawr=0, dmaaddr=0, dmawdata=0, state=IDLE, count=0, odd=0.
- Parity: odd toggles on every tick.
  - It is not cleared by DMA activity.
  - It is cleared only by reset.
- Page latch: on tick & wr4014 in IDLE, latch page=cpuwdata and count=0.
  - halt and busy rise on that same edge.
  - wr4014 in any state other than IDLE is ignored; page is unchanged.
- States, all advances on tick:
  - IDLE: on wr4014 go to DUMMY.
  - DUMMY: one tick with no bus activity. Next state is ALIGN if odd=1 at this edge, else RD.
  - ALIGN: one idle tick, then RD.
  - RD: on entry drive dmaaddr={page,count}, dmawr=0, dmareq=1.
  - WR: on entry drive dmaaddr=OAMDATA_ADDR, dmawdata=latched byte, dmawr=1, dmareq=1.
  - After the WR phase, increment count.
    - If count was NBYTES-1, go to IDLE and drop halt and busy on that edge.
    - Otherwise go to RD.
- Bus handshake, independent of tick:
  - dmareq stays high until dmaack is sampled.
  - dmareq drops on the clk edge after the ack cycle.
  - On a read ack, capture dmardata into the byte register on that edge.
  - A phase is complete once acked.
  - The state machine leaves RD/WR at the first tick edge at or after the ack edge; if ack and tick coincide, the state advances on that edge.
  - While a phase is not complete, ticks are absorbed and the state holds.
- dmaaddr, dmawdata and dmawr are stable for the whole time dmareq is high.
- dmaack while dmareq=0 is ignored.
- Width/wrap:
  - count is an 8-bit counter.
  - The address low byte equals count, so the source never crosses the page; page FF reads FF00..FFFF.
- Timing with immediate ack:
  - Even start: 1 + 2*NBYTES = 513 ticks from the wr4014 edge to halt falling.
  - Odd start: 514 ticks.
- Reset mid-transfer: return to IDLE with halt=0 and dmareq=0 immediately on the next edge.
  - Any pending ack is discarded.
  - No further writes are issued.
- Simultaneous reset and wr4014: reset wins.

Test Plan:
- Even-parity start, page 8'h02, memory holds byte i at 16'h0200+i, dmaack tied to dmareq:
  - Expect 256 writes to 16'h2004 with data 0..255 in order.
  - Expect reads at 0200..02FF.
  - halt high for exactly 513 ticks.
- Same stimulus with odd=1 at the DUMMY edge: exactly one ALIGN tick; halt high for 514 ticks; data identical.
- Ack delayed 3 clk cycles on every phase, tick every 4th clk:
  - dmareq held stable until ack, then drops on the next edge.
  - No lost or duplicated bytes.
  - Final write data 8'hFF.
- Page 8'hFF: last read address 16'hFFFF, last write to 16'h2004; count wraps to 0 and the state goes to IDLE.
- Second wr4014 with page 8'h05 during an active page-02 transfer: ignored; all reads stay in 0200..02FF.
- reset pulsed during RD of byte 100 (count=100) with dmareq high:
  - Next edge: halt=0, dmareq=0, busy=0.
  - No further writes.
  - A new wr4014 then restarts from count 0.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite DMA engine behind $4014: copies one CPU page into OAMDATA.
// Owns the shared CPU bus and stalls the CPU core for the whole transfer.
module oam_dma #(
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int          NBYTES       = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        wr4014,
    input  logic [7:0]  cpuwdata,
    output logic        halt,
    output logic [15:0] dmaaddr,
    output logic [7:0]  dmawdata,
    output logic        dmawr,
    output logic        dmareq,
    input  logic        dmaack,
    input  logic [7:0]  dmardata,
    output logic        busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DUMMY = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] WR    = 3'd4;

    localparam logic [7:0] LAST = 8'(NBYTES - 1);

    logic [2:0] state;
    logic [7:0] page;
    logic [7:0] count;
    logic [7:0] byte_q;
    logic       odd;
    logic       done;
    logic       ack;
    logic       complete;

    // Acks are only meaningful while a request is outstanding.
    assign ack      = dmareq & dmaack;
    assign complete = done | ack;
    assign busy     = (state != IDLE);
    assign halt     = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            page     <= 8'h00;
            count    <= 8'h00;
            byte_q   <= 8'h00;
            odd      <= 1'b0;
            done     <= 1'b0;
            dmareq   <= 1'b0;
            dmawr    <= 1'b0;
            dmaaddr  <= 16'h0000;
            dmawdata <= 8'h00;
        end else begin
            if (ack) begin
                dmareq <= 1'b0;
                done   <= 1'b1;
                if (!dmawr) byte_q <= dmardata;
            end
            if (tick) begin
                odd <= ~odd;
                case (state)
                    IDLE: begin
                        if (wr4014) begin
                            page  <= cpuwdata;
                            count <= 8'h00;
                            state <= DUMMY;
                        end
                    end
                    DUMMY: begin
                        if (odd) begin
                            state <= ALIGN;
                        end else begin
                            state   <= RD;
                            dmaaddr <= {page, count};
                            dmawr   <= 1'b0;
                            dmareq  <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                    ALIGN: begin
                        state   <= RD;
                        dmaaddr <= {page, count};
                        dmawr   <= 1'b0;
                        dmareq  <= 1'b1;
                        done    <= 1'b0;
                    end
                    RD: begin
                        if (complete) begin
                            state    <= WR;
                            dmaaddr  <= OAMDATA_ADDR;
                            dmawdata <= ack ? dmardata : byte_q;
                            dmawr    <= 1'b1;
                            dmareq   <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                    WR: begin
                        if (complete) begin
                            count <= count + 8'd1;
                            done  <= 1'b0;
                            if (count == LAST) begin
                                state  <= IDLE;
                                dmareq <= 1'b0;
                            end else begin
                                state   <= RD;
                                dmaaddr <= {page, count + 8'd1};
                                dmawr   <= 1'b0;
                                dmareq  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: bus model with optional ack delay,
// transaction monitor, and assertion checks in one linear sequence.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick = 1'b0;
    logic        wr4014;
    logic [7:0]  cpuwdata;
    logic        halt;
    logic [15:0] dmaaddr;
    logic [7:0]  dmawdata;
    logic        dmawr;
    logic        dmareq;
    logic        dmaack;
    logic [7:0]  dmardata;
    logic        busy;

    oam_dma dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .wr4014   (wr4014),
        .cpuwdata (cpuwdata),
        .halt     (halt),
        .dmaaddr  (dmaaddr),
        .dmawdata (dmawdata),
        .dmawr    (dmawr),
        .dmareq   (dmareq),
        .dmaack   (dmaack),
        .dmardata (dmardata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int tick_div  = 1;
    int div_cnt   = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;

    logic [7:0] key      = 8'h00;
    logic [7:0] exp_page = 8'h00;

    int          rd_cnt, wr_cnt, bad, bad_stab, halt_ticks, ticks_done;
    logic [15:0] last_raddr;
    logic [7:0]  last_wdata;
    logic        p_req, p_ack, p_tick, p_wr;
    logic [15:0] p_addr;
    logic [7:0]  p_data;

    // Memory: byte at address A is A[7:0] ^ key.
    assign dmardata = dmaaddr[7:0] ^ key;
    assign dmaack   = dmareq && (ack_delay == 0 || wait_cnt == ack_delay);

    always @(posedge clk) begin
        if (!dmareq || dmaack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        #1;
        if (div_cnt >= tick_div - 1) div_cnt = 0;
        else div_cnt = div_cnt + 1;
        tick = (div_cnt == 0);
    end

    // Monitor samples mid-cycle, when everything for the next edge is stable.
    always @(negedge clk) begin
        if (reset) begin
            ticks_done = 0;
            p_req = 1'b0;
            p_ack = 1'b0;
        end else begin
            if (dmareq && dmaack) begin
                if (dmawr) begin
                    if (dmaaddr != 16'h2004 || dmawdata != (wr_cnt[7:0] ^ key))
                        bad = bad + 1;
                    last_wdata = dmawdata;
                    wr_cnt = wr_cnt + 1;
                end else begin
                    if (dmaaddr != {exp_page, rd_cnt[7:0]}) bad = bad + 1;
                    last_raddr = dmaaddr;
                    rd_cnt = rd_cnt + 1;
                end
            end
            if (p_req && !p_ack) begin
                if (!dmareq || dmaaddr != p_addr || dmawr != p_wr ||
                    (dmawr && dmawdata != p_data))
                    bad_stab = bad_stab + 1;
            end
            if (p_req && p_ack && !p_tick && dmareq) bad_stab = bad_stab + 1;
            if (halt && tick) halt_ticks = halt_ticks + 1;
            if (tick) ticks_done = ticks_done + 1;
            p_req  = dmareq;
            p_ack  = dmaack;
            p_tick = tick;
            p_wr   = dmawr;
            p_addr = dmaaddr;
            p_data = dmawdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr_stats(input logic [7:0] pg, input logic [7:0] k);
        exp_page   = pg;
        key        = k;
        rd_cnt     = 0;
        wr_cnt     = 0;
        bad        = 0;
        bad_stab   = 0;
        halt_ticks = 0;
        last_raddr = 16'h0;
        last_wdata = 8'h0;
    endtask

    // Issue $4014 on a tick edge; want_odd<0 means any parity.
    task automatic issue_wr(input logic [7:0] pg, input int want_odd);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #2;
            if (tick && (want_odd < 0 || ((ticks_done + 1) % 2) == want_odd))
                break;
        end
        wr4014   = 1'b1;
        cpuwdata = pg;
        @(posedge clk);
        #2;
        wr4014 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (!busy) break;
            @(posedge clk);
            #2;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        wr4014   = 1'b0;
        cpuwdata = 8'h00;
        clr_stats(8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        check("rst_halt", {31'b0, halt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_req", {31'b0, dmareq}, 32'd0);
        check("rst_wr", {31'b0, dmawr}, 32'd0);
        check("rst_addr", {16'b0, dmaaddr}, 32'd0);
        check("rst_wdata", {24'b0, dmawdata}, 32'd0);
        reset = 1'b0;

        // Even start, immediate ack.
        clr_stats(8'h02, 8'h00);
        issue_wr(8'h02, 0);
        check("even_halt_up", {31'b0, halt}, 32'd1);
        check("even_busy_up", {31'b0, busy}, 32'd1);
        wait_idle("even_idle", 2000);
        check("even_rd", rd_cnt, 256);
        check("even_wr", wr_cnt, 256);
        check("even_bad", bad, 0);
        check("even_halt", halt_ticks, 513);
        check("even_last_ra", {16'b0, last_raddr}, 32'h02FF);
        check("even_last_wd", {24'b0, last_wdata}, 32'hFF);

        // Odd start: one ALIGN tick.
        clr_stats(8'h02, 8'h00);
        issue_wr(8'h02, 1);
        wait_idle("odd_idle", 2000);
        check("odd_halt", halt_ticks, 514);
        check("odd_wr", wr_cnt, 256);
        check("odd_bad", bad, 0);

        // Ack delayed 3 clocks, tick every 4th clock.
        tick_div  = 4;
        ack_delay = 3;
        clr_stats(8'h02, 8'h00);
        issue_wr(8'h02, -1);
        wait_idle("slow_idle", 20000);
        check("slow_rd", rd_cnt, 256);
        check("slow_wr", wr_cnt, 256);
        check("slow_bad", bad, 0);
        check("slow_stab", bad_stab, 0);
        check("slow_last_wd", {24'b0, last_wdata}, 32'hFF);
        tick_div  = 1;
        ack_delay = 0;

        // Top page, scrambled data.
        clr_stats(8'hFF, 8'h5A);
        issue_wr(8'hFF, -1);
        wait_idle("ff_idle", 2000);
        check("ff_last_ra", {16'b0, last_raddr}, 32'hFFFF);
        check("ff_last_wd", {24'b0, last_wdata}, 32'hA5);
        check("ff_wr", wr_cnt, 256);
        check("ff_bad", bad, 0);

        // Second $4014 mid-transfer must be ignored.
        clr_stats(8'h02, 8'h00);
        issue_wr(8'h02, -1);
        repeat (40) @(posedge clk);
        issue_wr(8'h05, -1);
        wait_idle("ign_idle", 2000);
        check("ign_rd", rd_cnt, 256);
        check("ign_bad", bad, 0);
        repeat (10) @(posedge clk);
        #2;
        check("ign_no_restart", {31'b0, busy}, 32'd0);

        // Reset while reading byte 100 with the request pending.
        ack_delay = 3;
        clr_stats(8'h02, 8'h00);
        issue_wr(8'h02, -1);
        for (int i = 0; i < 5000; i++) begin
            if (rd_cnt == 100 && dmareq && !dmawr && !dmaack) break;
            @(posedge clk);
            #2;
        end
        check("mid_addr", {16'b0, dmaaddr}, 32'h0264);
        check("mid_req", {31'b0, dmareq}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        check("mid_halt", {31'b0, halt}, 32'd0);
        check("mid_dreq", {31'b0, dmareq}, 32'd0);
        check("mid_busy", {31'b0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #2;
        check("mid_no_wr", wr_cnt, 100);
        ack_delay = 0;
        clr_stats(8'h02, 8'h00);
        issue_wr(8'h02, -1);
        wait_idle("restart_idle", 2000);
        check("restart_rd", rd_cnt, 256);
        check("restart_bad", bad, 0);

        // Reset beats a simultaneous $4014.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #2;
            if (tick) break;
        end
        reset    = 1'b1;
        wr4014   = 1'b1;
        cpuwdata = 8'h03;
        @(posedge clk);
        #2;
        reset  = 1'b0;
        wr4014 = 1'b0;
        check("rstwr_busy", {31'b0, busy}, 32'd0);
        check("rstwr_halt", {31'b0, halt}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
